// File: rtl/fetch_queue.sv
// fetch_queue: PC generator feeding a DEPTH-entry instruction queue.
// Inputs: Clock, Reset, PCSel/BranchPC (redirect), Stall, IMemData.
// Outputs: IMemAddr, Instruction_ID, PCPlusFour_ID, Valid_ID, Count, Full, Empty.
module fetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         PCSel,
    input  logic [DATA_WIDTH-1:0]        BranchPC,
    input  logic                         Stall,
    output logic [DATA_WIDTH-1:0]        IMemAddr,
    input  logic [DATA_WIDTH-1:0]        IMemData,
    output logic [DATA_WIDTH-1:0]        Instruction_ID,
    output logic [DATA_WIDTH-1:0]        PCPlusFour_ID,
    output logic                         Valid_ID,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Full,
    output logic                         Empty
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PC_STEP);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_next;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count_q;
    logic                  push;
    logic                  pop;

    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] pc4_mem   [DEPTH];

    assign pc_next  = pc + STEP;
    assign IMemAddr = pc;
    assign Count    = count_q;
    assign Empty    = (count_q == '0);
    assign Full     = (count_q == DEPTH_C);
    assign Valid_ID = !Empty;

    // A redirect suppresses both ends so wrong-path work never moves.
    assign pop  = Valid_ID && !Stall && !PCSel;
    assign push = !PCSel && (!Full || pop);

    // Decode sees a NOP (all zeros) whenever the queue is empty.
    assign Instruction_ID = Empty ? '0 : instr_mem[rd_ptr];
    assign PCPlusFour_ID  = Empty ? '0 : pc4_mem[rd_ptr];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc      <= RESET_PC;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (PCSel) begin
            pc      <= BranchPC;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                pc     <= pc_next;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge Clock) begin
        if (push) begin
            instr_mem[wr_ptr] <= IMemData;
            pc4_mem[wr_ptr]   <= pc_next;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue (DEPTH=4), plus a
// second instance with RESET_PC near the top of the address space.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        pcsel;
    logic [31:0] branch_pc;
    logic        stall;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    logic        rst_w;
    logic        pcsel_w;
    logic [31:0] branch_w;
    logic        stall_w;
    logic [31:0] addr_w;
    logic [31:0] data_w;
    logic [31:0] instr_w;
    logic [31:0] pc4_w;
    logic        valid_w;
    logic [2:0]  count_w;
    logic        full_w;
    logic        empty_w;

    int vectors;
    int miscompares;

    // Memory returns word = address.
    assign data   = addr;
    assign data_w = addr_w;

    fetch_queue #(.DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .Clock(clk), .Reset(rst), .PCSel(pcsel), .BranchPC(branch_pc),
        .Stall(stall), .IMemAddr(addr), .IMemData(data),
        .Instruction_ID(instr), .PCPlusFour_ID(pc4), .Valid_ID(valid),
        .Count(count), .Full(full), .Empty(empty)
    );

    fetch_queue #(.DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_w (
        .Clock(clk), .Reset(rst_w), .PCSel(pcsel_w), .BranchPC(branch_w),
        .Stall(stall_w), .IMemAddr(addr_w), .IMemData(data_w),
        .Instruction_ID(instr_w), .PCPlusFour_ID(pc4_w), .Valid_ID(valid_w),
        .Count(count_w), .Full(full_w), .Empty(empty_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; pcsel = 1'b0; stall = 1'b0; branch_pc = '0;
        #2;
        vectors++;
        if (addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_addr got %h want %h", addr, 32'h0);
        end
        vectors++;
        if ({valid, empty, full, count} !== {3'b010, 3'd0}) begin
            miscompares++;
            $display("FAIL reset_flags got v%b e%b f%b c%0d want v0 e1 f0 c0",
                     valid, empty, full, count);
        end
        vectors++;
        if ({instr, pc4} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_head got %h/%h want 0/0", instr, pc4);
        end
        tick;
        vectors++;
        if ({addr, count} !== {32'h0, 3'd0}) begin
            miscompares++;
            $display("FAIL reset_hold got %h c%0d want 0 c0", addr, count);
        end
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick;
            vectors++;
            if (addr !== 32'(4*i)) begin
                miscompares++;
                $display("FAIL stream_addr[%0d] got %h want %h", i, addr, 32'(4*i));
            end
            vectors++;
            if ({instr, pc4} !== {32'(4*(i-1)), 32'(4*i)}) begin
                miscompares++;
                $display("FAIL stream_head[%0d] got %h/%h want %h/%h",
                         i, instr, pc4, 32'(4*(i-1)), 32'(4*i));
            end
            vectors++;
            if ({valid, count} !== {1'b1, 3'd1}) begin
                miscompares++;
                $display("FAIL stream_cnt[%0d] got v%b c%0d want v1 c1", i, valid, count);
            end
        end
    endtask

    task automatic test_stall;
        int m;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        stall = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick;
            m = (i < 4) ? i : 4;
            vectors++;
            if ({count, full} !== {3'(m), (i >= 4)}) begin
                miscompares++;
                $display("FAIL stall_cnt[%0d] got c%0d f%b want c%0d f%b",
                         i, count, full, m, (i >= 4));
            end
            vectors++;
            if ({instr, addr} !== {32'h0, 32'(4*m)}) begin
                miscompares++;
                $display("FAIL stall_head[%0d] got %h addr %h want 0 addr %h",
                         i, instr, addr, 32'(4*m));
            end
        end
        stall = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick;
            vectors++;
            if ({instr, pc4, count} !== {32'(4*i), 32'(4*i+4), 3'd4}) begin
                miscompares++;
                $display("FAIL drain[%0d] got %h/%h c%0d want %h/%h c4",
                         i, instr, pc4, count, 32'(4*i), 32'(4*i+4));
            end
        end
    endtask

    task automatic test_redirect_full;
        vectors++;
        if (full !== 1'b1) begin
            miscompares++;
            $display("FAIL redir_pre_full got %b want 1", full);
        end
        branch_pc = 32'h100;
        pcsel = 1'b1;
        tick;
        pcsel = 1'b0;
        vectors++;
        if ({count, valid, empty} !== {3'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL redir_flush got c%0d v%b e%b want c0 v0 e1", count, valid, empty);
        end
        vectors++;
        if ({instr, pc4, addr} !== {32'h0, 32'h0, 32'h100}) begin
            miscompares++;
            $display("FAIL redir_bubble got %h/%h addr %h want 0/0 addr 100", instr, pc4, addr);
        end
        tick;
        vectors++;
        if ({instr, pc4, count, addr} !== {32'h100, 32'h104, 3'd1, 32'h104}) begin
            miscompares++;
            $display("FAIL redir_target got %h/%h c%0d addr %h want 100/104 c1 addr 104",
                     instr, pc4, count, addr);
        end
    endtask

    task automatic test_redirect_stall;
        stall = 1'b1;
        tick;
        tick;
        tick;
        vectors++;
        if ({count, full, instr} !== {3'd4, 1'b1, 32'h100}) begin
            miscompares++;
            $display("FAIL rs_fill got c%0d f%b head %h want c4 f1 head 100", count, full, instr);
        end
        branch_pc = 32'h200;
        pcsel = 1'b1;
        tick;
        pcsel = 1'b0;
        vectors++;
        if ({count, valid, addr} !== {3'd0, 1'b0, 32'h200}) begin
            miscompares++;
            $display("FAIL rs_flush got c%0d v%b addr %h want c0 v0 addr 200", count, valid, addr);
        end
        tick;
        vectors++;
        if ({count, instr, addr} !== {3'd1, 32'h200, 32'h204}) begin
            miscompares++;
            $display("FAIL rs_first got c%0d %h addr %h want c1 200 addr 204", count, instr, addr);
        end
        tick;
        vectors++;
        if ({count, instr} !== {3'd2, 32'h200}) begin
            miscompares++;
            $display("FAIL rs_held got c%0d %h want c2 200", count, instr);
        end
    endtask

    task automatic test_async_reset;
        tick;
        vectors++;
        if (count !== 3'd3) begin
            miscompares++;
            $display("FAIL ar_pre got c%0d want c3", count);
        end
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({count, valid, empty, full} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL ar_flags got c%0d v%b e%b f%b want c0 v0 e1 f0",
                     count, valid, empty, full);
        end
        vectors++;
        if ({instr, pc4, addr} !== {32'h0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL ar_out got %h/%h addr %h want 0/0 addr 0", instr, pc4, addr);
        end
        #2;
        rst = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_wrap;
        logic [31:0] exp;
        vectors++;
        if (addr_w !== 32'hFFFF_FFF8) begin
            miscompares++;
            $display("FAIL wrap_reset got %h want fffffff8", addr_w);
        end
        rst_w = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            tick;
            exp = 32'hFFFF_FFF8 + 32'(4*(n-1));
            vectors++;
            if ({instr_w, pc4_w, addr_w} !== {exp, exp + 32'd4, exp + 32'd4}) begin
                miscompares++;
                $display("FAIL wrap_run[%0d] got %h/%h addr %h want %h/%h addr %h",
                         n, instr_w, pc4_w, addr_w, exp, exp + 32'd4, exp + 32'd4);
            end
        end
        stall_w = 1'b1;
        tick;
        tick;
        tick;
        vectors++;
        if ({count_w, full_w, instr_w, addr_w} !== {3'd4, 1'b1, 32'hC, 32'h1C}) begin
            miscompares++;
            $display("FAIL wrap_fill got c%0d f%b %h addr %h want c4 f1 c addr 1c",
                     count_w, full_w, instr_w, addr_w);
        end
        stall_w = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick;
            vectors++;
            if ({instr_w, count_w} !== {32'(12 + 4*k), 3'd4}) begin
                miscompares++;
                $display("FAIL wrap_drain[%0d] got %h c%0d want %h c4",
                         k, instr_w, count_w, 32'(12 + 4*k));
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_w = 1'b1;
        pcsel_w = 1'b0;
        stall_w = 1'b0;
        branch_w = '0;
        test_reset;
        test_stall;
        test_redirect_full;
        test_redirect_stall;
        test_async_reset;
        test_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
